// File: rtl/variable_latency_adder_if.sv
// Valid/ready bundle for variable_latency_adder.
// The block side uses slave; the producer/consumer side uses master.
interface variable_latency_adder_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             approx_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err_detected;
  logic             corrected;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, a, b, approx_mode, out_ready,
    input  in_ready, out_valid, sum, cout,
    input  err_detected, corrected, err_count
  );

  modport slave (
    input  in_valid, a, b, approx_mode, out_ready,
    output in_ready, out_valid, sum, cout,
    output err_detected, corrected, err_count
  );
endinterface

// File: rtl/variable_latency_adder.sv
// Window-limited speculative adder with optional one-cycle
// exact correction and a saturating speculation-error counter.
module variable_latency_adder #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  variable_latency_adder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SPEC,
    CORR,
    OUT
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] a_q, b_q;
  logic             am_q;

  logic [WIDTH-1:0] p, g;
  logic [WIDTH:0]   cs, cx;
  logic [WIDTH-1:0] sum_s, sum_x;
  logic             err;
  logic             cw, cr;

  logic take, ld_spec, ld_corr;

  assign p = a_q ^ b_q;
  assign g = a_q & b_q;

  // cs[i]: carry from a chain restarted WINDOW bits below i
  always_comb begin
    cs = '0;
    cx = '0;
    cw = 1'b0;
    cr = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      cw = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && j + WINDOW >= i)
          cw = g[j] | (p[j] & cw);
      end
      cs[i] = cw;
      cr = g[i-1] | (p[i-1] & cr);
      cx[i] = cr;
    end
  end

  assign sum_s = p ^ cs[WIDTH-1:0];
  assign sum_x = p ^ cx[WIDTH-1:0];
  assign err   = |(cs[WIDTH:1] ^ cx[WIDTH:1]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    ld_spec = 1'b0;
    ld_corr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          take    = 1'b1;
          state_n = SPEC;
        end
      end
      SPEC: begin
        if (err && !am_q) begin
          state_n = CORR;
        end else begin
          ld_spec = 1'b1;
          state_n = OUT;
        end
      end
      CORR: begin
        ld_corr = 1'b1;
        state_n = OUT;
      end
      OUT: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q              <= '0;
      b_q              <= '0;
      am_q             <= 1'b0;
      bus.sum          <= '0;
      bus.cout         <= 1'b0;
      bus.err_detected <= 1'b0;
      bus.corrected    <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      if (take) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        am_q <= bus.approx_mode;
      end
      if (ld_spec) begin
        bus.sum          <= sum_s;
        bus.cout         <= cs[WIDTH];
        bus.err_detected <= err;
        bus.corrected    <= 1'b0;
      end
      if (ld_corr) begin
        bus.sum          <= sum_x;
        bus.cout         <= cx[WIDTH];
        bus.err_detected <= 1'b1;
        bus.corrected    <= 1'b1;
      end
      if (state == SPEC && err && bus.err_count != '1)
        bus.err_count <= bus.err_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
